// File: rtl/rx_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_sink_pkg
// Description : Shared types and helpers for the receive-side packet sink:
//               handshake FSM state encoding and a saturating increment.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_sink_pkg;

  // Handshake states toward the Decoder
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } rx_state_t;

  // Widest counter the saturating helper supports
  localparam int c_sat_w = 32;

  // Increment value, holding at the all-ones pattern of the low 'width' bits.
  // Callers zero-extend their counter in and truncate the result back out.
  function automatic logic [c_sat_w-1:0] sat_inc(
    input logic [c_sat_w-1:0] value,
    input int                 width
  );
    logic [c_sat_w-1:0] max_val;
    max_val = {c_sat_w{1'b1}} >> (c_sat_w - width);
    return (value == max_val) ? value : (value + c_sat_w'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with power-of-2 depth. Head is read
//               combinationally from storage. A push while full is accepted
//               only when a pop frees a slot in the same cycle. flush empties
//               the FIFO and takes priority over push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == c_cnt_w'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = pop && !w_empty;
  assign w_do_push = push && (!w_full || w_do_pop);

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = w_full;
  assign empty    = w_empty;

  // Storage write; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_packet_sink.sv
`default_nettype none
// ============================================================================
// Module      : rx_packet_sink
// Description : Receive-side consumer for the pulse-link Decoder. Acks each
//               packet over avail/read, buffers it in a FIFO, checks it
//               against an expected value, keeps saturating pkt/err/drop
//               counters and runs a sticky link-loss watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_packet_sink
  import rx_sink_pkg::*;
#(
  parameter int N_PKT   = 8,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1_000_000,
  parameter int TO_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_PKT-1:0] data_rcv,
  input  logic             avail_rcv,
  output logic             read,
  input  logic [N_PKT-1:0] expected,
  input  logic             clear,
  output logic [N_PKT-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_PKT-1:0] last_data,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             timeout
);

  localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

  rx_state_t        r_state;
  logic             r_read;
  logic [N_PKT-1:0] r_last_data;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [TO_W-1:0]  r_wd_cnt;
  logic             r_timeout;

  logic w_accept;
  logic w_push;
  logic w_drop;
  logic w_full;
  logic w_empty;

  // ACK is the single cycle in which the packet is sampled; clear suppresses
  // the push and counting but the read strobe still releases the Decoder.
  assign w_accept = (r_state == ACK);
  assign w_push   = w_accept && !clear;
  // A pop while full frees a slot, so only a full FIFO without pop drops
  assign w_drop   = w_push && w_full && !out_ready;

  sync_fifo #(
    .WIDTH (N_PKT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (data_rcv),
    .pop       (out_ready),
    .flush     (clear),
    .pop_data  (out_data),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Handshake FSM: one accept per avail pulse, read registered with state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_read  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (avail_rcv) begin
            r_state <= ACK;
            r_read  <= 1'b1;
          end
        end
        ACK: begin
          r_state <= WAIT_LOW;
          r_read  <= 1'b0;
        end
        WAIT_LOW: begin
          if (!avail_rcv) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_read  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating statistics, zeroed by clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_cnt  <= '0;
      r_err_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (clear) begin
      r_pkt_cnt  <= '0;
      r_err_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (w_push) begin
      r_pkt_cnt <= CNT_W'(sat_inc(c_sat_w'(r_pkt_cnt), CNT_W));
      if (data_rcv != expected) begin
        r_err_cnt <= CNT_W'(sat_inc(c_sat_w'(r_err_cnt), CNT_W));
      end
      if (w_drop) begin
        r_drop_cnt <= CNT_W'(sat_inc(c_sat_w'(r_drop_cnt), CNT_W));
      end
    end
  end

  // Last accepted packet, captured even when dropped; clear leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_data <= '0;
    end else if (w_accept) begin
      r_last_data <= data_rcv;
    end
  end

  // Link-loss watchdog: freezes once timeout is flagged until ACK or clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (clear || w_accept) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (!r_timeout) begin
      if (r_wd_cnt == c_to_last) begin
        r_timeout <= 1'b1;
      end else begin
        r_wd_cnt <= r_wd_cnt + TO_W'(1);
      end
    end
  end

  assign read      = r_read;
  assign out_valid = !w_empty;
  assign last_data = r_last_data;
  assign pkt_cnt   = r_pkt_cnt;
  assign err_cnt   = r_err_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire
